echo_receiver: RTL

Receive-side partner of the LiDAR laser pulse generator. Watches the emitted-pulse reference (START), then timestamps up to MAX_ECHO rising edges of the photodiode comparator output (ECHO) within a bounded listening window. Streams the captured time-of-flight counts to the downstream range-processing logic over a valid/ready interface.

---
 rtl/lidar_pkg.sv | 13 +
 rtl/echo_sync.sv | 61 ++++++
 rtl/echo_receiver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lidar_pkg.sv
// Shared LiDAR receive-path types: FSM state encoding, default counter width, no-hit marker.
package lidar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LISTEN = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam int COUNTER_WIDTH_DEF = 17;
   localparam logic [COUNTER_WIDTH_DEF-1:0] NOHIT_TOF = '1;

endpackage

// File: rtl/echo_sync.sv
// ECHO synchronizer + rising-edge detect; ECHO_FILTER_EN adds a MIN_WIDTH high-time filter.
// rise fires 2 cycles after ECHO goes high (gated by arm); accept marks a confirmed echo; no backpressure.
module echo_sync
`ifdef ECHO_FILTER_EN
#(
   parameter int MIN_WIDTH = 2
)
`endif
(
   input  logic CLK,
   input  logic RST,
   input  logic ECHO,
   input  logic arm,
   input  logic clr,
   output logic rise,
   output logic accept
);

   logic s1, s2, s3;

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= ECHO;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3 & arm;

`ifdef ECHO_FILTER_EN
   localparam logic [7:0] MW = 8'(MIN_WIDTH);

   logic       pend;
   logic [7:0] hi_cnt;

   // hi_cnt counts synchronized high cycles since the candidate's rise, rise cycle included.
   always_ff @(posedge CLK) begin
      if (RST || clr) begin
         pend   <= 1'b0;
         hi_cnt <= 8'd0;
      end else if (rise) begin
         pend   <= (MW > 8'd1);
         hi_cnt <= 8'd1;
      end else if (pend) begin
         if (!s2 || accept)
            pend <= 1'b0;
         hi_cnt <= hi_cnt + 8'd1;
      end
   end

   assign accept = (rise && (MW <= 8'd1)) || (pend && s2 && ((hi_cnt + 8'd1) == MW));
`else
   assign accept = rise;
`endif

endmodule

// File: rtl/echo_receiver.sv
// Timestamps up to MAX_ECHO echoes per START inside a bounded window, then streams TOF records.
// First record one cycle after REPORT entry, one per cycle with READY high, held while VALID&~READY.
// Optional pulse-width filter on ECHO when ECHO_FILTER_EN is defined.
module echo_receiver
   import lidar_pkg::*;
#(
   parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF,
   parameter int MAX_ECHO      = 3,
   parameter int BLANK         = 4,
   parameter int WINDOW_MAX    = 99999
`ifdef ECHO_FILTER_EN
  ,parameter int MIN_WIDTH     = 2
`endif
)(
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     EN,
   input  logic                     START,
   input  logic                     ECHO,
   input  logic                     READY,
   output logic                     VALID,
   output logic [COUNTER_WIDTH-1:0] TOF,
   output logic [2:0]               IDX,
   output logic                     LAST,
   output logic                     NOHIT,
   output logic                     START_MISS
);

   localparam logic [COUNTER_WIDTH-1:0] BLANK_C   = COUNTER_WIDTH'(BLANK);
   localparam logic [COUNTER_WIDTH-1:0] WIN_C     = COUNTER_WIDTH'(WINDOW_MAX);
   localparam logic [COUNTER_WIDTH-1:0] NOHIT_C   = '1;
   localparam logic [2:0]               MAX_C     = 3'(MAX_ECHO);

   state_t                     state;
   logic [COUNTER_WIDTH-1:0]   cnt;
   logic [COUNTER_WIDTH-1:0]   cand;
   logic [COUNTER_WIDTH-1:0]   slot [MAX_ECHO];
   logic [2:0]                 n;
   logic                       start_d;

   logic                       start_rise, listening, arm, clr, rise, accept;
   logic [COUNTER_WIDTH-1:0]   cap_val, rd_tof;
   logic [2:0]                 nxt_idx;
   logic                       nxt_last;

   assign start_rise = START & ~start_d;
   assign listening  = (state == LISTEN) && EN;
   assign arm        = listening && (cnt >= BLANK_C);
   assign clr        = ~listening;

   echo_sync
`ifdef ECHO_FILTER_EN
   #(.MIN_WIDTH(MIN_WIDTH))
`endif
   u_sync (
      .CLK    (CLK),
      .RST    (RST),
      .ECHO   (ECHO),
      .arm    (arm),
      .clr    (clr),
      .rise   (rise),
      .accept (accept)
   );

   // A filtered echo is confirmed after its rise; the stored TOF is always the rise-cycle count.
   assign cap_val = rise ? cnt : cand;

   assign nxt_idx  = VALID ? (IDX + 3'd1) : 3'd0;
   assign nxt_last = (n == 3'd0) || (nxt_idx == (n - 3'd1));

   always_comb begin
      rd_tof = NOHIT_C;
      for (int i = 0; i < MAX_ECHO; i++)
         if (nxt_idx == 3'(i))
            rd_tof = slot[i];
      if (n == 3'd0)
         rd_tof = NOHIT_C;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         cnt        <= '0;
         cand       <= '0;
         n          <= 3'd0;
         start_d    <= 1'b0;
         VALID      <= 1'b0;
         TOF        <= '0;
         IDX        <= 3'd0;
         LAST       <= 1'b0;
         NOHIT      <= 1'b0;
         START_MISS <= 1'b0;
         for (int i = 0; i < MAX_ECHO; i++)
            slot[i] <= '0;
      end else begin
         start_d    <= START;
         START_MISS <= start_rise && (state != IDLE);
         if (rise)
            cand <= cnt;

         if (!EN) begin
            state <= IDLE;
            VALID <= 1'b0;
            n     <= 3'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_rise) begin
                     cnt   <= '0;
                     n     <= 3'd0;
                     state <= LISTEN;
                  end
               end
               LISTEN: begin
                  cnt <= cnt + COUNTER_WIDTH'(1);
                  if (accept) begin
                     for (int i = 0; i < MAX_ECHO; i++)
                        if (n == 3'(i))
                           slot[i] <= cap_val;
                     n <= n + 3'd1;
                  end
                  if ((accept && (n == (MAX_C - 3'd1))) || (cnt == WIN_C))
                     state <= REPORT;
               end
               REPORT: begin
                  if (VALID && READY && LAST) begin
                     VALID <= 1'b0;
                     state <= IDLE;
                  end else if (!VALID || READY) begin
                     VALID <= 1'b1;
                     TOF   <= rd_tof;
                     IDX   <= nxt_idx;
                     LAST  <= nxt_last;
                     NOHIT <= (n == 3'd0);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
